aes128_cfb_stream_ctrl: RTL

AES128_CFB_STREAM_CTRL -- requirements
Module: aes128_cfb_stream_ctrl

---
 rtl/aes128_cfb_pkg.sv | 28 ++
 rtl/aes128_cfb_seg_mask.sv | 11 +
 rtl/aes128_cfb_stream_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aes128_cfb_pkg.sv
// rtl/aes128_cfb_pkg.sv - shared types, constants and segment-mask helper for the CFB stream controller
package aes128_cfb_pkg;

    localparam int         SEG_ENC_MAX_DEFAULT = 7;
    localparam logic [3:0] CFB_MODE            = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_IN  = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_ENG = 3'd4,
        ST_OUT      = 3'd5
    } state_t;

    typedef struct packed {
        logic         decrypt;
        logic [2:0]   seg_len;
        logic [127:0] key;
        logic [127:0] iv;
    } cfg_t;

    // Code n selects the top 2**n bits of the 128-bit block.
    function automatic logic [127:0] seg_mask(input logic [2:0] code);
        return ~({128{1'b1}} >> (8'd1 << code));
    endfunction

endpackage

// File: rtl/aes128_cfb_seg_mask.sv
// rtl/aes128_cfb_seg_mask.sv - combinational segment-length code to MSB-aligned bit mask
module aes128_cfb_seg_mask
    import aes128_cfb_pkg::*;
(
    input  logic [2:0]   code,
    output logic [127:0] mask
);

    assign mask = seg_mask(code);

endmodule

// File: rtl/aes128_cfb_stream_ctrl.sv
// rtl/aes128_cfb_stream_ctrl.sv - sequences one CFB segment at a time through an external aes128 engine
module aes128_cfb_stream_ctrl
    import aes128_cfb_pkg::*;
#(
    parameter int SEG_ENC_MAX = SEG_ENC_MAX_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [2:0]   seg_len,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_seg,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_seg,
    output logic         out_last,
    output logic         eng_cipher_en,
    output logic         eng_decipher_en,
    output logic         eng_chain_en,
    output logic [127:0] eng_data_in,
    output logic [127:0] eng_key,
    output logic [127:0] eng_init_vector,
    output logic [3:0]   eng_mode,
    output logic [15:0]  eng_segment_len,
    input  logic [127:0] eng_data_out,
    input  logic         eng_ready,
    output logic         busy,
    output logic         err
);

    state_t       state_q;
    state_t       state_d;
    cfg_t         cfg_q;
    logic [127:0] data_q;
    logic [127:0] res_q;
    logic         last_q;
    logic         eng_ready_q;
    logic         err_q;
    logic [127:0] mask;
    logic         cfg_legal;
    logic         eng_rise;

    aes128_cfb_seg_mask u_seg_mask (
        .code (cfg_q.seg_len),
        .mask (mask)
    );

    assign cfg_legal = int'(seg_len) <= SEG_ENC_MAX;
    assign eng_rise  = eng_ready && !eng_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start && cfg_legal) state_d = ST_ARM;
            ST_ARM:      state_d = ST_WAIT_IN;
            ST_WAIT_IN:  if (in_valid) state_d = ST_ISSUE;
            ST_ISSUE:    state_d = ST_WAIT_ENG;
            ST_WAIT_ENG: if (eng_rise) state_d = ST_OUT;
            ST_OUT:      if (out_ready) state_d = last_q ? ST_IDLE : ST_WAIT_IN;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy            = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        eng_cipher_en   = 1'b0;
        eng_decipher_en = 1'b0;
        eng_chain_en    = 1'b0;
        case (state_q)
            ST_ARM: begin
                busy = 1'b1;
            end
            ST_WAIT_IN: begin
                busy         = 1'b1;
                in_ready     = 1'b1;
                eng_chain_en = 1'b1;
            end
            ST_ISSUE: begin
                busy            = 1'b1;
                eng_chain_en    = 1'b1;
                eng_cipher_en   = !cfg_q.decrypt;
                eng_decipher_en = cfg_q.decrypt;
            end
            ST_WAIT_ENG: begin
                busy         = 1'b1;
                eng_chain_en = 1'b1;
            end
            ST_OUT: begin
                busy         = 1'b1;
                eng_chain_en = 1'b1;
                out_valid    = 1'b1;
                out_last     = last_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Config, captured segment and result registers; the engine strobe is edge-detected here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            data_q      <= '0;
            res_q       <= '0;
            last_q      <= 1'b0;
            eng_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            eng_ready_q <= eng_ready;
            err_q       <= (state_q == ST_IDLE) && start && !cfg_legal;
            if ((state_q == ST_IDLE) && start && cfg_legal) begin
                cfg_q.decrypt <= decrypt;
                cfg_q.seg_len <= seg_len;
                cfg_q.key     <= key;
                cfg_q.iv      <= iv;
            end
            if ((state_q == ST_WAIT_IN) && in_valid) begin
                data_q <= in_seg & mask;
                last_q <= in_last;
            end
            if ((state_q == ST_WAIT_ENG) && eng_rise) begin
                res_q <= eng_data_out & mask;
            end
        end
    end

    assign out_seg         = res_q;
    assign err             = err_q;
    assign eng_data_in     = data_q;
    assign eng_key         = cfg_q.key;
    assign eng_init_vector = cfg_q.iv;
    assign eng_mode        = CFB_MODE;
    assign eng_segment_len = {13'd0, cfg_q.seg_len};

endmodule
